// File: rtl/jelly_ram_accumulator_mc.sv
// Multi-channel RAM accumulator: 2-stage read-modify-write pipeline with result forwarding,
// an independent read-first port, a running maximum tracker and a whole-memory clear sequencer.
module jelly_ram_accumulator_mc #(
  parameter int                    ADDR_WIDTH   = 3,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEM_SIZE     = 1 << ADDR_WIDTH,
  parameter bit                    SATURATE     = 1'b0,
  parameter logic [DATA_WIDTH-1:0] FILLMEM_DATA = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cke,
  input  logic [ADDR_WIDTH-1:0] acc_addr,
  input  logic [DATA_WIDTH-1:0] acc_data,
  input  logic [1:0]            acc_operation,
  input  logic                  acc_valid,
  output logic                  acc_ready,
  input  logic                  mem_en,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  clear_start,
  output logic                  clear_busy,
  input  logic                  max_clear,
  output logic [ADDR_WIDTH-1:0] max_addr,
  output logic [DATA_WIDTH-1:0] max_data,
  output logic                  overflow
);

  typedef enum logic [1:0] {IDLE, DRAIN, SWEEP} state_e;

  localparam logic [1:0]            OP_ADD    = 2'b00;
  localparam logic [1:0]            OP_SUB    = 2'b01;
  localparam logic [1:0]            OP_SET    = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  // Contents come from the configuration image only; reset never touches the array.
  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE] = '{default: FILLMEM_DATA};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_addr_q, sweep_addr_d;
  logic                  ready_q;
  logic                  s1_valid_q, s2_valid_q;
  logic [1:0]            s1_op_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q;
  logic [DATA_WIDTH-1:0] s1_data_q, s2_data_q;
  logic                  s2_ovf_q, overflow_q;
  logic [ADDR_WIDTH-1:0] max_addr_q;
  logic [DATA_WIDTH-1:0] max_data_q, mem_dout_q;
  logic [DATA_WIDTH-1:0] old_val, res_d;
  logic [DATA_WIDTH:0]   sum_val, diff_val;
  logic                  ovf_d, accept, sweep_start;

  assign accept      = acc_valid & ready_q & cke;
  assign sweep_start = (state_q == DRAIN) && (state_d == SWEEP);

  // Stage 1 sees either the word still waiting in stage 2 or the committed memory word.
  always_comb begin
    old_val  = (s2_valid_q && (s2_addr_q == s1_addr_q)) ? s2_data_q : mem_q[s1_addr_q];
    sum_val  = {1'b0, old_val} + {1'b0, s1_data_q};
    diff_val = {1'b0, old_val} - {1'b0, s1_data_q};
    res_d    = FILLMEM_DATA;
    ovf_d    = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        ovf_d = sum_val[DATA_WIDTH];
        res_d = (SATURATE && ovf_d) ? '1 : sum_val[DATA_WIDTH-1:0];
      end
      OP_SUB: begin
        ovf_d = diff_val[DATA_WIDTH];
        res_d = (SATURATE && ovf_d) ? '0 : diff_val[DATA_WIDTH-1:0];
      end
      OP_SET:  res_d = s1_data_q;
      default: res_d = FILLMEM_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
      s2_ovf_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (cke) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_op_q   <= acc_operation;
        s1_addr_q <= acc_addr;
        s1_data_q <= acc_data;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_addr_q <= s1_addr_q;
        s2_data_q <= res_d;
        s2_ovf_q  <= ovf_d;
      end
      overflow_q <= s2_valid_q & s2_ovf_q;
    end
  end

  // The sweep only runs once the pipeline has drained, so the two writers never collide.
  always_ff @(posedge clk) begin
    if (cke) begin
      if (s2_valid_q) begin
        mem_q[s2_addr_q] <= s2_data_q;
      end else if (state_q == SWEEP) begin
        mem_q[sweep_addr_q] <= FILLMEM_DATA;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_dout_q <= '0;
    end else if (cke && mem_en) begin
      mem_dout_q <= mem_q[mem_addr];
    end
  end

  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    case (state_q)
      IDLE: if (clear_start) state_d = DRAIN;
      DRAIN: begin
        if (!s1_valid_q) begin
          state_d      = SWEEP;
          sweep_addr_d = '0;
        end
      end
      SWEEP: begin
        if (sweep_addr_q == LAST_ADDR) state_d = IDLE;
        else sweep_addr_d = sweep_addr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sweep_addr_q <= '0;
      ready_q      <= 1'b0;
    end else if (cke) begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      ready_q      <= (state_d == IDLE);
    end
  end

  // A commit coinciding with max_clear reseeds the maximum with the committing word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_addr_q <= '0;
      max_data_q <= '0;
    end else if (cke) begin
      if (sweep_start) begin
        max_addr_q <= '0;
        max_data_q <= '0;
      end else if (s2_valid_q) begin
        if (max_clear || (s2_data_q > max_data_q)) begin
          max_addr_q <= s2_addr_q;
          max_data_q <= s2_data_q;
        end
      end else if (max_clear) begin
        max_addr_q <= '0;
        max_data_q <= '0;
      end
    end
  end

  assign acc_ready  = ready_q;
  assign clear_busy = (state_q != IDLE);
  assign overflow   = overflow_q;
  assign max_addr   = max_addr_q;
  assign max_data   = max_data_q;
  assign mem_dout   = mem_dout_q;

endmodule

// File: tb/tb_jelly_ram_accumulator_mc.sv
// Bench for jelly_ram_accumulator_mc: a saturating and a wrapping instance share one stimulus
// stream and are compared against a sequential array model of the accumulator.
module tb_jelly_ram_accumulator_mc;

  localparam int         AW   = 3;
  localparam int         DW   = 8;
  localparam int         SIZE = 1 << AW;
  localparam logic [7:0] FILL = 8'h11;

  logic          clk = 1'b0;
  logic          resetN;
  logic          cke;
  logic [AW-1:0] accAddr;
  logic [DW-1:0] accData;
  logic [1:0]    accOp;
  logic          accValid;
  logic          memEn;
  logic [AW-1:0] memAddr;
  logic          clearStart;
  logic          maxClear;
  logic [1:0]    accReady, clearBusy, overflow;
  logic [DW-1:0] memDout [2];
  logic [AW-1:0] maxAddr [2];
  logic [DW-1:0] maxData [2];

  int testsRun = 0;
  int testsFailed = 0;
  int modelMem [2][SIZE];
  int modelMax [2];
  int modelMaxAddr [2];
  int modelOvf [2];
  int ovfSeen [2];

  always #5 clk = ~clk;

  jelly_ram_accumulator_mc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(SIZE),
                             .SATURATE(1'b1), .FILLMEM_DATA(FILL)) dutSat (
    .clk(clk), .reset_n(resetN), .cke(cke), .acc_addr(accAddr), .acc_data(accData),
    .acc_operation(accOp), .acc_valid(accValid), .acc_ready(accReady[0]),
    .mem_en(memEn), .mem_addr(memAddr), .mem_dout(memDout[0]),
    .clear_start(clearStart), .clear_busy(clearBusy[0]), .max_clear(maxClear),
    .max_addr(maxAddr[0]), .max_data(maxData[0]), .overflow(overflow[0]));

  jelly_ram_accumulator_mc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(SIZE),
                             .SATURATE(1'b0), .FILLMEM_DATA(FILL)) dutWrap (
    .clk(clk), .reset_n(resetN), .cke(cke), .acc_addr(accAddr), .acc_data(accData),
    .acc_operation(accOp), .acc_valid(accValid), .acc_ready(accReady[1]),
    .mem_en(memEn), .mem_addr(memAddr), .mem_dout(memDout[1]),
    .clear_start(clearStart), .clear_busy(clearBusy[1]), .max_clear(maxClear),
    .max_addr(maxAddr[1]), .max_data(maxData[1]), .overflow(overflow[1]));

  // Overflow is a single-cycle pulse, so one sample per cycle counts each event once.
  always @(negedge clk) begin
    if (overflow[0]) ovfSeen[0]++;
    if (overflow[1]) ovfSeen[1]++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int modelOp(input bit sat, input int op, input int old, input int data, output bit ovf);
    int r;
    ovf = 1'b0;
    case (op)
      0: begin
        r = old + data;
        if (r > 255) begin ovf = 1'b1; r = sat ? 255 : r - 256; end
      end
      1: begin
        r = old - data;
        if (r < 0) begin ovf = 1'b1; r = sat ? 0 : r + 256; end
      end
      2: r = data;
      default: r = FILL;
    endcase
    return r;
  endfunction

  task automatic modelAccept(input int op, input int addr, input int data);
    int r;
    bit ovf;
    for (int k = 0; k < 2; k++) begin
      r = modelOp(k == 0, op, modelMem[k][addr], data, ovf);
      modelMem[k][addr] = r;
      if (ovf) modelOvf[k]++;
      if (r > modelMax[k]) begin
        modelMax[k] = r;
        modelMaxAddr[k] = addr;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int op, input int addr, input int data);
    checkOutput("accReady", 32'(accReady), 32'h3);
    accValid = 1'b1;
    accOp    = 2'(op);
    accAddr  = AW'(addr);
    accData  = DW'(data);
    @(posedge clk);
    if (cke && accReady == 2'b11) modelAccept(op, addr, data);
    #1;
    accValid = 1'b0;
  endtask

  task automatic readWord(input int addr, output logic [7:0] vSat, output logic [7:0] vWrap);
    memEn   = 1'b1;
    memAddr = AW'(addr);
    @(posedge clk);
    #1;
    memEn = 1'b0;
    vSat  = memDout[0];
    vWrap = memDout[1];
  endtask

  task automatic pulseMaxClear();
    maxClear = 1'b1;
    @(posedge clk);
    #1;
    maxClear = 1'b0;
    for (int k = 0; k < 2; k++) begin
      modelMax[k] = 0;
      modelMaxAddr[k] = 0;
    end
  endtask

  task automatic checkAll(input string tag);
    logic [7:0] vS, vW;
    idle(3);
    for (int a = 0; a < SIZE; a++) begin
      readWord(a, vS, vW);
      checkOutput({tag, ".memSat"}, 32'(vS), 32'(modelMem[0][a]));
      checkOutput({tag, ".memWrap"}, 32'(vW), 32'(modelMem[1][a]));
    end
    for (int k = 0; k < 2; k++) begin
      checkOutput({tag, ".maxData"}, 32'(maxData[k]), 32'(modelMax[k]));
      checkOutput({tag, ".maxAddr"}, 32'(maxAddr[k]), 32'(modelMaxAddr[k]));
      checkOutput({tag, ".ovfCount"}, 32'(ovfSeen[k]), 32'(modelOvf[k]));
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".ready"}, 32'(accReady), 32'h0);
    checkOutput({tag, ".busy"}, 32'(clearBusy), 32'h0);
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'h0);
    for (int k = 0; k < 2; k++) begin
      checkOutput({tag, ".maxData"}, 32'(maxData[k]), 32'h0);
      checkOutput({tag, ".maxAddr"}, 32'(maxAddr[k]), 32'h0);
      checkOutput({tag, ".memDout"}, 32'(memDout[k]), 32'h0);
    end
  endtask

  initial begin
    logic [7:0] vS, vW;
    logic [7:0] capSat, capWrap;
    int busyCnt [2];
    int expAddr7 [2];
    int op;

    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < SIZE; a++) modelMem[k][a] = FILL;
      modelMax[k] = 0; modelMaxAddr[k] = 0; modelOvf[k] = 0; ovfSeen[k] = 0;
    end
    resetN = 1'b0; cke = 1'b1; accValid = 1'b0; accOp = '0; accAddr = '0; accData = '0;
    memEn = 1'b0; memAddr = '0; clearStart = 1'b0; maxClear = 1'b0;

    idle(3);
    checkResetOutputs("reset");
    @(negedge clk);
    resetN = 1'b1;
    idle(1);
    checkOutput("readyAfterReset", 32'(accReady), 32'h3);

    readWord(0, vS, vW);
    checkOutput("initFill", 32'(vS), 32'(FILL));

    // Back-to-back updates exercise both forwarding distances.
    applyStimulus(2, 3, 0);
    applyStimulus(0, 3, 5);
    applyStimulus(0, 3, 7);
    idle(2);
    readWord(3, vS, vW);
    checkOutput("fwdSat", 32'(vS), 32'd12);
    checkOutput("fwdWrap", 32'(vW), 32'd12);

    applyStimulus(2, 1, 250);
    applyStimulus(0, 1, 10);
    idle(3);
    readWord(1, vS, vW);
    checkOutput("addClamp", 32'(vS), 32'd255);
    checkOutput("addWrap", 32'(vW), 32'd4);
    checkOutput("addOvfSat", 32'(ovfSeen[0]), 32'd1);
    checkOutput("addOvfWrap", 32'(ovfSeen[1]), 32'd1);
    applyStimulus(2, 6, 0);
    applyStimulus(1, 6, 300 & 8'hff);
    idle(3);
    readWord(6, vS, vW);
    checkOutput("subClamp", 32'(vS), 32'd0);
    checkOutput("subWrap", 32'(vW), 32'd212);
    checkOutput("subOvfSat", 32'(ovfSeen[0]), 32'd2);

    applyStimulus(2, 4, 8'h55);
    idle(1);
    readWord(4, vS, vW);
    checkOutput("readFirstOld", 32'(vS), 32'(FILL));
    readWord(4, vS, vW);
    checkOutput("readFirstNew", 32'(vW), 32'h55);

    pulseMaxClear();
    checkOutput("maxClearData", 32'(maxData[0]), 32'h0);
    applyStimulus(2, 2, 0);
    applyStimulus(2, 5, 0);
    applyStimulus(0, 2, 9);
    applyStimulus(0, 5, 9);
    idle(3);
    checkOutput("maxTieAddr", 32'(maxAddr[0]), 32'd2);
    checkOutput("maxTieData", 32'(maxData[1]), 32'd9);
    pulseMaxClear();
    checkOutput("maxClrAddr", 32'(maxAddr[1]), 32'h0);
    checkOutput("maxClrData", 32'(maxData[0]), 32'h0);

    applyStimulus(2, 0, 8'h77);
    cke = 1'b0;
    clearStart = 1'b1;
    idle(4);
    checkOutput("frozenNoClear", 32'(clearBusy), 32'h0);
    clearStart = 1'b0;
    cke = 1'b1;
    idle(2);
    readWord(0, vS, vW);
    checkOutput("frozenCommit", 32'(vS), 32'h77);

    // Clear request issued alongside the second of two in-flight operations.
    applyStimulus(0, 7, 3);
    clearStart = 1'b1;
    applyStimulus(0, 7, 4);
    clearStart = 1'b0;
    expAddr7[0] = modelMem[0][7];
    expAddr7[1] = modelMem[1][7];
    memEn = 1'b1;
    memAddr = AW'(7);
    busyCnt[0] = int'(clearBusy[0]);
    busyCnt[1] = int'(clearBusy[1]);
    capSat = '0; capWrap = '0;
    for (int i = 1; i <= 40 && clearBusy != 2'b00; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) begin capSat = memDout[0]; capWrap = memDout[1]; end
      busyCnt[0] += int'(clearBusy[0]);
      busyCnt[1] += int'(clearBusy[1]);
    end
    memEn = 1'b0;
    checkOutput("clearBusySat", 32'(busyCnt[0]), 32'(2 + SIZE));
    checkOutput("clearBusyWrap", 32'(busyCnt[1]), 32'(2 + SIZE));
    checkOutput("drainCommitSat", 32'(capSat), 32'(expAddr7[0]));
    checkOutput("drainCommitWrap", 32'(capWrap), 32'(expAddr7[1]));
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < SIZE; a++) modelMem[k][a] = FILL;
      modelMax[k] = 0; modelMaxAddr[k] = 0;
    end
    checkAll("afterClear");

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      op = (op < 4) ? 0 : (op < 8) ? 1 : (op == 8) ? 2 : 3;
      applyStimulus(op, $urandom_range(0, SIZE - 1), $urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    checkAll("random");

    expAddr7[0] = modelMem[0][7];
    expAddr7[1] = modelMem[1][7];
    clearStart = 1'b1;
    idle(1);
    clearStart = 1'b0;
    idle(5);
    resetN = 1'b0;
    #2;
    checkResetOutputs("midSweepReset");
    @(negedge clk);
    resetN = 1'b1;
    idle(1);
    checkOutput("readyAfterAbort", 32'(accReady), 32'h3);
    readWord(0, vS, vW);
    checkOutput("abortSweptSat", 32'(vS), 32'(FILL));
    checkOutput("abortSweptWrap", 32'(vW), 32'(FILL));
    readWord(7, vS, vW);
    checkOutput("abortUnsweptSat", 32'(vS), 32'(expAddr7[0]));
    checkOutput("abortUnsweptWrap", 32'(vW), 32'(expAddr7[1]));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
